toggle_handshake_rx: RTL
========================

Name: toggle_handshake_rx

Overview:
- Receiving end of a toggle (T flip-flop style) request/acknowledge link.
- The sending side toggles `req_tog` once per transfer and holds `data_in` stable until it sees `ack_tog` toggle.
- This block synchronises `req_tog`, detects each toggle, captures `data_in` into a valid/ready output register, and toggles `ack_tog` back once the local consumer accepts the word.
- It also keeps a saturating transfer counter and a sticky protocol-overrun flag.

Parameters:
- DATA_W, 8: width of `data_in` / `dout`.
- SYNC_STAGES, 2: flops in the `req_tog` synchroniser chain; legal values 2..4.
- CNT_W, 8: width of `evt_count`.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising `clk`.
- req_tog  input  1  request toggle from sender; asynchronous to this block, so it is synchronised.
- data_in  input  DATA_W  payload; stable from a `req_tog` toggle until the matching `ack_tog` toggle.
- ack_tog  output  1  acknowledge toggle to sender; one toggle per accepted word.
- dout  output  DATA_W  captured payload.
- dout_valid  output  1  `dout` holds an unconsumed word.
- dout_ready  input  1  consumer accepts `dout` when high together with `dout_valid`.
- evt_count  output  CNT_W  number of completed transfers, saturating.
- overrun  output  1  sticky flag: sender toggled again before acknowledge.

Behaviour:
- Reset (`rst_n`=0 at a rising edge): synchroniser chain=0, req_seen=0, state=IDLE.
  - Outputs: ack_tog=0, dout=0, dout_valid=0, evt_count=0, overrun=0.
  - Reset mid-transfer drops `dout_valid` at that edge and discards the word.
  - The sender is reset in the same domain, so no recovery handshake is defined.
- Synchroniser: `req_tog` -> sync[0] -> ... -> sync[SYNC_STAGES-1]; req_s = last stage.
- Toggle pending: req_s != req_seen.
- FSM states:
  - IDLE: `dout_valid`=0. If a toggle is pending, then at that edge:
    - dout <= data_in
    - req_seen <= req_s
    - dout_valid <= 1
    - go to VALID.
  - VALID: `dout_valid`=1, `dout` held constant. When dout_valid && dout_ready at an edge:
    - dout_valid <= 0
    - ack_tog <= ~ack_tog
    - evt_count <= evt_count+1, held at 2^CNT_W-1 once reached
    - go to IDLE.
- Latency (default SYNC_STAGES=2):
  - `req_tog` changes before edge k.
  - req_s reflects it after edge k+1.
  - `dout_valid` high after edge k+2.
- Handshake latency: with `dout_ready` held high, `ack_tog` toggles at the first edge where `dout_valid` is high, i.e. after edge k+3.
- Back-to-back: a toggle that becomes pending during or right after the accept edge is captured on the next IDLE cycle. Minimum of one IDLE cycle between words; no bubbles beyond that.
- Overrun:
  - Trigger: in VALID, a toggle is pending, i.e. a new req toggle was seen before `ack_tog`.
  - Action: overrun <= 1, sticky until reset.
  - That toggle is still captured normally after the return to IDLE.
  - Two toggles while in VALID are invisible (level unchanged). The word is lost, and `overrun` is already set by the first toggle.
- `dout_ready` with `dout_valid`=0: ignored; no state change.
- Simultaneous accept and new pending toggle in VALID: accept completes and `overrun` is set in the same edge.
- `data_in` is sampled only on the IDLE capture edge; changes at any other time have no effect.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 3 edges with req_tog=1 and data_in=8'hFF.
  - Required: all outputs 0; after release, first capture of 8'hFF occurs 2 edges later (req_s=1 differs from req_seen=0).
- Single transfer:
  - Stimulus: after reset, req_tog 0->1 with data_in=8'hA5 and dout_ready=1.
  - Required: dout_valid high after edge k+2, dout=8'hA5; ack_tog 0->1 after edge k+3; evt_count=1; overrun=0.
- Consumer stall:
  - Stimulus: same as single transfer but dout_ready=0 for 5 cycles, with data_in changed to 8'h00 during the stall.
  - Required: dout stays 8'hA5 and dout_valid stays high; ack_tog toggles only at the edge after dout_ready rises.
- Streaming:
  - Stimulus: sender toggles req_tog on each `ack_tog` change, data 8'h01..8'h04, dout_ready=1.
  - Required: dout sequence 01, 02, 03, 04, none lost; ack_tog ends at 0; evt_count=4.
- Overrun:
  - Stimulus: hold dout_ready=0 and toggle req_tog twice more, 4 cycles apart, data 8'h11 then 8'h22.
  - Required: overrun=1 and stays 1; dout keeps the first word; after the accept no further capture (level back to seen value).
- Saturation and mid-reset:
  - Stimulus: CNT_W=2, run 5 transfers, then assert rst_n=0 while dout_valid=1.
  - Required: evt_count reads 3 after the 3rd, 4th and 5th transfers; at the reset edge dout_valid=0, evt_count=0, ack_tog=0.

Source files
------------

// File: rtl/toggle_handshake_rx.sv
// Receive side of a toggle request/acknowledge link. It synchronises req_tog and
// captures data_in into a valid/ready register. It toggles ack_tog back once the word is consumed.
module toggle_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_tog,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tog,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_seen_q, req_seen_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   ack_q, ack_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   req_s;
    logic                   pending;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign pending = (req_s != req_seen_q);

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], req_tog};
        req_seen_d = req_seen_q;
        dout_d     = dout_q;
        ack_d      = ack_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    dout_d     = data_in;
                    req_seen_d = req_s;
                    state_d    = VALID;
                end
            end
            VALID: begin
                // A new toggle before our ack means the sender broke the protocol;
                // it is still captured after the return to IDLE.
                if (pending) begin
                    overrun_d = 1'b1;
                end
                if (dout_ready) begin
                    state_d = IDLE;
                    ack_d   = ~ack_q;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            dout_q     <= '0;
            ack_q      <= 1'b0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            req_seen_q <= req_seen_d;
            dout_q     <= dout_d;
            ack_q      <= ack_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign ack_tog    = ack_q;
    assign dout       = dout_q;
    assign dout_valid = (state_q == VALID);
    assign evt_count  = cnt_q;
    assign overrun    = overrun_q;

endmodule
